// File: rtl/lsu_bus_wb_queue_if.sv
// Bus-completion and writeback-arbiter signals of the LSU bus writeback queue.
// The slave modport is the queue's view, and the master modport is the environment's view.
interface lsu_bus_wb_queue_if #(
  parameter int ROB_INDEX_WIDTH    = 4,
  parameter int PHY_REG_ADDR_WIDTH = 6,
  parameter int XLEN               = 64
);
  // Handshakes: a completion transfers when bus_resp_vld_i & bus_resp_rdy_o are
  // both high at a rising edge. The head transfers when bus_wb_arb_wb_vld_o &
  // wb_arb_bus_rdy_i are both high. A valid source holds its payload until the transfer.
  logic                          bus_resp_vld_i;
  logic                          bus_resp_rdy_o;
  logic [ROB_INDEX_WIDTH-1:0]    bus_resp_rob_index_i;
  logic                          bus_resp_is_load_i;
  logic [PHY_REG_ADDR_WIDTH-1:0] bus_resp_rd_addr_i;
  logic [XLEN-1:0]               bus_resp_data_i;
  logic [2:0]                    bus_resp_offset_i;
  logic [1:0]                    bus_resp_size_i;
  logic                          bus_resp_unsigned_i;

  logic                          bus_wb_arb_wb_vld_o;
  logic [ROB_INDEX_WIDTH-1:0]    bus_wb_arb_wb_rob_index_o;
  logic                          bus_wb_arb_prf_wb_vld_o;
  logic [PHY_REG_ADDR_WIDTH-1:0] bus_wb_arb_prf_wb_rd_addr_o;
  logic [XLEN-1:0]               bus_wb_arb_prf_wb_data_o;
  logic                          wb_arb_bus_rdy_i;

  modport slave (
    input  bus_resp_vld_i, bus_resp_rob_index_i, bus_resp_is_load_i,
           bus_resp_rd_addr_i, bus_resp_data_i, bus_resp_offset_i,
           bus_resp_size_i, bus_resp_unsigned_i, wb_arb_bus_rdy_i,
    output bus_resp_rdy_o, bus_wb_arb_wb_vld_o, bus_wb_arb_wb_rob_index_o,
           bus_wb_arb_prf_wb_vld_o, bus_wb_arb_prf_wb_rd_addr_o,
           bus_wb_arb_prf_wb_data_o
  );

  modport master (
    output bus_resp_vld_i, bus_resp_rob_index_i, bus_resp_is_load_i,
           bus_resp_rd_addr_i, bus_resp_data_i, bus_resp_offset_i,
           bus_resp_size_i, bus_resp_unsigned_i, wb_arb_bus_rdy_i,
    input  bus_resp_rdy_o, bus_wb_arb_wb_vld_o, bus_wb_arb_wb_rob_index_o,
           bus_wb_arb_prf_wb_vld_o, bus_wb_arb_prf_wb_rd_addr_o,
           bus_wb_arb_prf_wb_data_o
  );
endinterface

// File: rtl/lsu_bus_wb_queue.sv
// In-order FIFO of formatted bus load/store completions feeding the LSU writeback arbiter.
// Load data is shifted, truncated and extended at enqueue, so the head is a pure register read.
module lsu_bus_wb_queue #(
  parameter int DEPTH              = 4,
  parameter int ROB_INDEX_WIDTH    = 4,
  parameter int PHY_REG_ADDR_WIDTH = 6,
  parameter int XLEN               = 64
) (
  input  logic clk,
  input  logic rstn,
  input  logic flush_i,
  lsu_bus_wb_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef struct packed {
    logic [ROB_INDEX_WIDTH-1:0]    rob_index;
    logic                          prf_vld;
    logic [PHY_REG_ADDR_WIDTH-1:0] rd_addr;
    logic [XLEN-1:0]               data;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          wr_entry;
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            not_empty;
  logic            push;
  logic            pop;

  // Misaligned offset/size pairs are not rejected; they simply shift then truncate.
  function automatic logic [XLEN-1:0] format_load(
    input logic [XLEN-1:0] raw,
    input logic [2:0]      offset,
    input logic [1:0]      size,
    input logic            is_unsigned
  );
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] res;
    shifted = raw >> {offset, 3'b000};
    case (size)
      2'd0:    res = {{56{~is_unsigned & shifted[7]}},  shifted[7:0]};
      2'd1:    res = {{48{~is_unsigned & shifted[15]}}, shifted[15:0]};
      2'd2:    res = {{32{~is_unsigned & shifted[31]}}, shifted[31:0]};
      default: res = shifted;
    endcase
    return res;
  endfunction

  assign not_empty          = (count != '0);
  assign bus.bus_resp_rdy_o = (count != FULL_COUNT);
  assign push = bus.bus_resp_vld_i & bus.bus_resp_rdy_o & ~flush_i;
  assign pop  = not_empty & bus.wb_arb_bus_rdy_i & ~flush_i;

  always_comb begin
    wr_entry           = '0;
    wr_entry.rob_index = bus.bus_resp_rob_index_i;
    wr_entry.prf_vld   = bus.bus_resp_is_load_i & (bus.bus_resp_rd_addr_i != '0);
    wr_entry.rd_addr   = bus.bus_resp_rd_addr_i;
    wr_entry.data      = format_load(bus.bus_resp_data_i, bus.bus_resp_offset_i,
                                     bus.bus_resp_size_i, bus.bus_resp_unsigned_i);
  end

  // Payload storage is only ever observed through a non-empty count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  assign bus.bus_wb_arb_wb_vld_o         = not_empty;
  assign bus.bus_wb_arb_wb_rob_index_o   = not_empty ? head.rob_index : '0;
  assign bus.bus_wb_arb_prf_wb_vld_o     = not_empty & head.prf_vld;
  assign bus.bus_wb_arb_prf_wb_rd_addr_o = not_empty ? head.rd_addr : '0;
  assign bus.bus_wb_arb_prf_wb_data_o    = not_empty ? head.data : '0;
endmodule

// File: tb/tb_lsu_bus_wb_queue.sv
// Bench for lsu_bus_wb_queue: directed scenarios plus random traffic, all checked
// against a queue-based reference of formatted completions.
module tb_lsu_bus_wb_queue;
  localparam int DEPTH = 4;
  localparam int RW    = 4;
  localparam int PW    = 6;
  localparam int XLEN  = 64;
  localparam int EW    = RW + 1 + PW + XLEN;

  logic clk;
  logic rstn;
  logic flush;

  lsu_bus_wb_queue_if #(.ROB_INDEX_WIDTH(RW), .PHY_REG_ADDR_WIDTH(PW), .XLEN(XLEN)) bus ();

  lsu_bus_wb_queue #(
    .DEPTH(DEPTH), .ROB_INDEX_WIDTH(RW), .PHY_REG_ADDR_WIDTH(PW), .XLEN(XLEN)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .flush_i(flush),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference formatting: arithmetic on the byte offset and the access width.
  function automatic logic [63:0] ref_format(input logic [63:0] raw, input int off,
                                             input int size, input logic uns);
    logic [63:0] s;
    logic [63:0] mask;
    int nbits;
    s = raw >> (off * 8);
    if (size == 3) return s;
    nbits = 8 << size;
    mask  = (64'd1 << nbits) - 64'd1;
    s     = s & mask;
    if (!uns && s[nbits-1]) s = s | ~mask;
    return s;
  endfunction

  task automatic check_outputs(input string tag);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, ":wb_vld"},  64'(bus.bus_wb_arb_wb_vld_o), 64'd0);
      check({tag, ":prf_vld"}, 64'(bus.bus_wb_arb_prf_wb_vld_o), 64'd0);
      check({tag, ":rob"},     64'(bus.bus_wb_arb_wb_rob_index_o), 64'd0);
      check({tag, ":rd"},      64'(bus.bus_wb_arb_prf_wb_rd_addr_o), 64'd0);
      check({tag, ":data"},    bus.bus_wb_arb_prf_wb_data_o, 64'd0);
    end else begin
      e = exp_q[0];
      check({tag, ":wb_vld"},  64'(bus.bus_wb_arb_wb_vld_o), 64'd1);
      check({tag, ":rob"},     64'(bus.bus_wb_arb_wb_rob_index_o), 64'(e[EW-1 -: RW]));
      check({tag, ":prf_vld"}, 64'(bus.bus_wb_arb_prf_wb_vld_o), 64'(e[XLEN+PW]));
      check({tag, ":rd"},      64'(bus.bus_wb_arb_prf_wb_rd_addr_o), 64'(e[XLEN +: PW]));
      check({tag, ":data"},    bus.bus_wb_arb_prf_wb_data_o, e[XLEN-1:0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_resp(input logic vld, input int rob, input logic is_load, input int rd,
                            input logic [63:0] data, input int off, input int size,
                            input logic uns);
    bus.bus_resp_vld_i       = vld;
    bus.bus_resp_rob_index_i = RW'(rob);
    bus.bus_resp_is_load_i   = is_load;
    bus.bus_resp_rd_addr_i   = PW'(rd);
    bus.bus_resp_data_i      = data;
    bus.bus_resp_offset_i    = 3'(off);
    bus.bus_resp_size_i      = 2'(size);
    bus.bus_resp_unsigned_i  = uns;
  endtask

  task automatic idle_resp();
    drive_resp(1'b0, 0, 1'b0, 0, 64'd0, 0, 0, 1'b0);
  endtask

  // Called one time unit after a rising edge. Predicts the transfer from the
  // reference occupancy, advances one clock and compares the new head.
  task automatic tick(input string tag);
    logic do_push;
    logic do_pop;
    logic [EW-1:0] e;
    check({tag, ":rdy_o"}, 64'(bus.bus_resp_rdy_o), 64'(exp_q.size() != DEPTH));
    do_push = bus.bus_resp_vld_i && (exp_q.size() != DEPTH) && !flush;
    do_pop  = (exp_q.size() != 0) && bus.wb_arb_bus_rdy_i && !flush;
    e = {bus.bus_resp_rob_index_i,
         bus.bus_resp_is_load_i && (bus.bus_resp_rd_addr_i != 0),
         bus.bus_resp_rd_addr_i,
         ref_format(bus.bus_resp_data_i, int'(bus.bus_resp_offset_i),
                    int'(bus.bus_resp_size_i), bus.bus_resp_unsigned_i)};
    @(posedge clk);
    if (flush) exp_q.delete();
    else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(e);
    end
    #1;
    check_outputs(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn  = 1'b0;
    flush = 1'b0;
    bus.wb_arb_bus_rdy_i = 1'b0;
    idle_resp();
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("reset");
    check("reset:rdy_o", 64'(bus.bus_resp_rdy_o), 64'd1);

    // Load formatting, queued behind a stalled arbiter.
    drive_resp(1'b1, 1, 1'b1, 7, 64'h8877_6655_4433_2211, 4, 1, 1'b0); tick("fmt_push");
    drive_resp(1'b1, 2, 1'b1, 8, 64'h8877_6655_4433_2211, 7, 0, 1'b0); tick("fmt_push");
    drive_resp(1'b1, 3, 1'b1, 9, 64'h8877_6655_4433_2211, 7, 0, 1'b1); tick("fmt_push");
    idle_resp();
    check("fmt_half_signed", bus.bus_wb_arb_prf_wb_data_o, 64'h0000_0000_0000_6655);
    bus.wb_arb_bus_rdy_i = 1'b1;
    tick("fmt_pop");
    check("fmt_byte_signed", bus.bus_wb_arb_prf_wb_data_o, 64'hFFFF_FFFF_FFFF_FF88);
    tick("fmt_pop");
    check("fmt_byte_unsigned", bus.bus_wb_arb_prf_wb_data_o, 64'h0000_0000_0000_0088);
    tick("fmt_pop");

    // Store then x0 load: LSQ writeback only.
    bus.wb_arb_bus_rdy_i = 1'b0;
    drive_resp(1'b1, 5, 1'b0, 12, 64'h1234, 0, 3, 1'b0); tick("st_push");
    drive_resp(1'b1, 6, 1'b1, 0, 64'h5678, 0, 3, 1'b0);  tick("x0_push");
    idle_resp();
    check("st_rob", 64'(bus.bus_wb_arb_wb_rob_index_o), 64'd5);
    check("st_prf_vld", 64'(bus.bus_wb_arb_prf_wb_vld_o), 64'd0);
    bus.wb_arb_bus_rdy_i = 1'b1;
    tick("st_pop");
    check("x0_rob", 64'(bus.bus_wb_arb_wb_rob_index_o), 64'd6);
    check("x0_prf_vld", 64'(bus.bus_wb_arb_prf_wb_vld_o), 64'd0);
    tick("x0_pop");

    // Fill to DEPTH under backpressure; a 5th completion must stall.
    bus.wb_arb_bus_rdy_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive_resp(1'b1, i, 1'b1, 10 + i, {$urandom, $urandom}, 0, 3, 1'b0);
      tick("full_push");
    end
    check("full_rdy_low", 64'(bus.bus_resp_rdy_o), 64'd0);
    drive_resp(1'b1, 9, 1'b1, 20, 64'hDEAD, 0, 3, 1'b0);
    tick("full_5th");
    check("full_head", 64'(bus.bus_wb_arb_wb_rob_index_o), 64'd1);
    idle_resp();
    bus.wb_arb_bus_rdy_i = 1'b1;
    tick("drain");
    check("drain_rdy_back", 64'(bus.bus_resp_rdy_o), 64'd1);
    check("drain_rob2", 64'(bus.bus_wb_arb_wb_rob_index_o), 64'd2);
    tick("drain");
    check("drain_rob3", 64'(bus.bus_wb_arb_wb_rob_index_o), 64'd3);
    tick("drain");
    check("drain_rob4", 64'(bus.bus_wb_arb_wb_rob_index_o), 64'd4);
    tick("drain");

    // Back-to-back stream with the arbiter always ready: occupancy stays at one.
    for (int i = 0; i < 10; i++) begin
      drive_resp(1'b1, i, 1'b1, i + 1, {$urandom, $urandom}, $urandom_range(0, 7),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      tick("stream");
      check("stream_rob", 64'(bus.bus_wb_arb_wb_rob_index_o), 64'(i));
    end
    idle_resp();
    tick("stream_end");

    // Flush with a concurrent push and pop.
    bus.wb_arb_bus_rdy_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_resp(1'b1, 8 + i, 1'b1, 30 + i, {$urandom, $urandom}, 0, 3, 1'b0);
      tick("pre_flush");
    end
    drive_resp(1'b1, 15, 1'b1, 40, 64'hF1F1, 0, 3, 1'b0);
    bus.wb_arb_bus_rdy_i = 1'b1;
    flush = 1'b1;
    tick("flush");
    flush = 1'b0;
    idle_resp();
    check("flush_wb_vld", 64'(bus.bus_wb_arb_wb_vld_o), 64'd0);
    check("flush_rdy_o", 64'(bus.bus_resp_rdy_o), 64'd1);
    tick("post_flush");

    // Asynchronous reset in the middle of traffic.
    bus.wb_arb_bus_rdy_i = 1'b0;
    drive_resp(1'b1, 3, 1'b1, 3, 64'h77, 0, 3, 1'b0); tick("pre_rst");
    drive_resp(1'b1, 4, 1'b1, 4, 64'h88, 0, 3, 1'b0); tick("pre_rst");
    rstn = 1'b0;
    #1;
    exp_q.delete();
    check_outputs("async_rst");
    check("async_rst:rdy_o", 64'(bus.bus_resp_rdy_o), 64'd1);
    idle_resp();
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("after_rst");

    // Random traffic with occasional flushes.
    for (int i = 0; i < 2000; i++) begin
      drive_resp(1'($urandom_range(0, 3) != 0), $urandom_range(0, 15),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63),
                 {$urandom, $urandom}, $urandom_range(0, 7), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)));
      bus.wb_arb_bus_rdy_i = 1'($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 49) == 0);
      tick("rand");
    end
    flush = 1'b0;
    idle_resp();
    bus.wb_arb_bus_rdy_i = 1'b1;
    repeat (DEPTH + 1) tick("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
